player1_ctrl: RTL

- Per-frame motion, collision and animation controller for player 1.
- Produces the sprite position (centerX1/centerY1) and frame index (sprite_num) consumed by the player1 sprite renderer.
- Once per video frame it samples the buttons and checks the destination against the wall map through a req/ack tile-query handshake, then commits or rejects the move.
- Also sequences death and respawn.

---
 rtl/bomberman_pkg.sv | 34 +++
 rtl/player1_corner_calc.sv | 60 ++++++
 rtl/player1_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bomberman_pkg.sv
// Shared types and constants for the player controllers: FSM states, facing
// direction, sprite frame bases and tile-query payload.
package bomberman_pkg;

    localparam int unsigned TILE_SHIFT  = 5;
    localparam int unsigned SPRITE_SIZE = 32;
    localparam int unsigned TILE_W      = 5;
    localparam int unsigned POS_W       = 11;
    localparam int unsigned CAND_W      = 12;
    localparam int unsigned SPR_W       = 3;

    localparam logic [SPR_W-1:0] SPR_DOWN = 3'd0;
    localparam logic [SPR_W-1:0] SPR_UP   = 3'd2;
    localparam logic [SPR_W-1:0] SPR_SIDE = 3'd4;
    localparam logic [SPR_W-1:0] SPR_DEAD = 3'd6;

    typedef enum logic [2:0] {IDLE, EVAL, Q1, Q2, COMMIT, DEAD} ctrl_state_t;
    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

    typedef struct packed {
        logic [TILE_W-1:0] tx;
        logic [TILE_W-1:0] ty;
    } tile_t;

    // Walk-frame base for a facing direction; left and right share frames.
    function automatic logic [SPR_W-1:0] base_sprite(input dir_t d);
        case (d)
            UP:      return SPR_UP;
            DOWN:    return SPR_DOWN;
            default: return SPR_SIDE;
        endcase
    endfunction

endpackage

// File: rtl/player1_corner_calc.sv
// Candidate position, play-area bounds check and the two leading-edge corner
// tiles for one step of the 32x32 player sprite in a given direction.
module player1_corner_calc
    import bomberman_pkg::*;
#(
    parameter int STEP    = 2,
    parameter int HACTIVE = 800,
    parameter int VACTIVE = 600
) (
    input  dir_t                     dir,
    input  logic signed [POS_W-1:0] pos_x,
    input  logic signed [POS_W-1:0] pos_y,
    output logic signed [CAND_W-1:0] cand_x,
    output logic signed [CAND_W-1:0] cand_y,
    output logic                     in_bounds,
    output tile_t                    corner1,
    output tile_t                    corner2
);

    localparam logic signed [CAND_W-1:0] STEP_S = CAND_W'(STEP);
    localparam logic signed [CAND_W-1:0] MAX_X  = CAND_W'(HACTIVE - int'(SPRITE_SIZE));
    localparam logic signed [CAND_W-1:0] MAX_Y  = CAND_W'(VACTIVE - int'(SPRITE_SIZE));
    localparam logic signed [CAND_W-1:0] EDGE   = CAND_W'(SPRITE_SIZE - 1);

    logic signed [CAND_W-1:0] lead_x;
    logic signed [CAND_W-1:0] lead_y;
    logic signed [CAND_W-1:0] far_x;
    logic signed [CAND_W-1:0] far_y;

    always_comb begin
        cand_x = CAND_W'(pos_x);
        cand_y = CAND_W'(pos_y);
        case (dir)
            UP:      cand_y = cand_y - STEP_S;
            DOWN:    cand_y = cand_y + STEP_S;
            LEFT:    cand_x = cand_x - STEP_S;
            default: cand_x = cand_x + STEP_S;
        endcase

        in_bounds = !cand_x[CAND_W-1] && (cand_x <= MAX_X) &&
                    !cand_y[CAND_W-1] && (cand_y <= MAX_Y);

        // First corner sits on the leading edge; the second runs along it.
        lead_x = cand_x;
        lead_y = cand_y;
        if (dir == RIGHT) lead_x = cand_x + EDGE;
        if (dir == DOWN)  lead_y = cand_y + EDGE;

        far_x = lead_x;
        far_y = lead_y;
        if (dir == LEFT || dir == RIGHT) far_y = lead_y + EDGE;
        else                             far_x = lead_x + EDGE;

        corner1.tx = TILE_W'(lead_x >>> TILE_SHIFT);
        corner1.ty = TILE_W'(lead_y >>> TILE_SHIFT);
        corner2.tx = TILE_W'(far_x >>> TILE_SHIFT);
        corner2.ty = TILE_W'(far_y >>> TILE_SHIFT);
    end

endmodule

// File: rtl/player1_ctrl.sv
// Player 1 per-frame motion, wall-collision, walk animation and death/respawn.
// Walk-frame toggling is built only when PLAYER_ANIM_EN is defined.
module player1_ctrl
    import bomberman_pkg::*;
#(
    parameter int START_X      = 32,
    parameter int START_Y      = 32,
    parameter int STEP         = 2,
    parameter int ANIM_DIV     = 8,
    parameter int DEATH_FRAMES = 60,
    parameter int HACTIVE      = 800,
    parameter int VACTIVE      = 600
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_tick,
    input  logic                     btn_up,
    input  logic                     btn_down,
    input  logic                     btn_left,
    input  logic                     btn_right,
    input  logic                     hit,
    output logic                     map_req,
    output logic [TILE_W-1:0]        map_tx,
    output logic [TILE_W-1:0]        map_ty,
    input  logic                     map_ack,
    input  logic                     map_free,
    output logic signed [POS_W-1:0]  centerX1,
    output logic signed [POS_W-1:0]  centerY1,
    output logic [SPR_W-1:0]         sprite_num,
    output logic                     alive
);

    localparam int unsigned DCNT_W = (DEATH_FRAMES < 2) ? 1 : $clog2(DEATH_FRAMES + 1);

    if (STEP < 1 || STEP > 31 || ANIM_DIV < 1) begin : g_param_check
        $error("player1_ctrl: STEP must be 1..31 and ANIM_DIV must be >= 1");
    end

    ctrl_state_t             state_q, state_d;
    dir_t                    dir_q, dir_d;
    logic signed [POS_W-1:0] pos_x_q, pos_x_d;
    logic signed [POS_W-1:0] pos_y_q, pos_y_d;
    logic [SPR_W-1:0]        sprite_q, sprite_d;
    logic                    map_req_q, map_req_d;
    tile_t                   tile_q, tile_d;
    logic                    alive_q, alive_d;
    logic [DCNT_W-1:0]       death_cnt_q, death_cnt_d;
`ifdef PLAYER_ANIM_EN
    localparam int unsigned ACNT_W = (ANIM_DIV < 2) ? 1 : $clog2(ANIM_DIV + 1);
    logic [ACNT_W-1:0]       anim_q, anim_d;
    logic                    frame_q, frame_d;
`endif

    logic                     btn_any;
    dir_t                     btn_dir;
    dir_t                     calc_dir;
    logic signed [CAND_W-1:0] cand_x, cand_y;
    logic                     in_bounds;
    tile_t                    corner1, corner2;

    // Fixed priority up > down > left > right.
    always_comb begin
        btn_any = btn_up | btn_down | btn_left | btn_right;
        btn_dir = RIGHT;
        if      (btn_up)   btn_dir = UP;
        else if (btn_down) btn_dir = DOWN;
        else if (btn_left) btn_dir = LEFT;
        calc_dir = (state_q == EVAL) ? btn_dir : dir_q;
    end

    player1_corner_calc #(
        .STEP    (STEP),
        .HACTIVE (HACTIVE),
        .VACTIVE (VACTIVE)
    ) u_corner_calc (
        .dir       (calc_dir),
        .pos_x     (pos_x_q),
        .pos_y     (pos_y_q),
        .cand_x    (cand_x),
        .cand_y    (cand_y),
        .in_bounds (in_bounds),
        .corner1   (corner1),
        .corner2   (corner2)
    );

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        sprite_d    = sprite_q;
        map_req_d   = map_req_q;
        tile_d      = tile_q;
        alive_d     = alive_q;
        death_cnt_d = death_cnt_q;
`ifdef PLAYER_ANIM_EN
        anim_d      = anim_q;
        frame_d     = frame_q;
`endif

        case (state_q)
            IDLE: begin
                if (frame_tick) state_d = EVAL;
            end

            EVAL: begin
                state_d = IDLE;
                if (!btn_any) begin
                    sprite_d = base_sprite(dir_q);
`ifdef PLAYER_ANIM_EN
                    anim_d  = '0;
                    frame_d = 1'b0;
`endif
                end else begin
                    dir_d = btn_dir;
`ifdef PLAYER_ANIM_EN
                    if (btn_dir != dir_q) begin
                        anim_d  = '0;
                        frame_d = 1'b0;
                    end
                    sprite_d = base_sprite(btn_dir) | {2'b00, frame_d};
`else
                    sprite_d = base_sprite(btn_dir);
`endif
                    if (in_bounds) begin
                        state_d   = Q1;
                        map_req_d = 1'b1;
                        tile_d    = corner1;
                    end
                end
            end

            Q1: begin
                if (map_req_q && map_ack) begin
                    map_req_d = 1'b0;
                    state_d   = map_free ? Q2 : IDLE;
                end
            end

            // Entered with the request low so the handshake sees a gap between queries.
            Q2: begin
                if (!map_req_q) begin
                    map_req_d = 1'b1;
                    tile_d    = corner2;
                end else if (map_ack) begin
                    map_req_d = 1'b0;
                    state_d   = map_free ? COMMIT : IDLE;
                end
            end

            COMMIT: begin
                pos_x_d = POS_W'(cand_x);
                pos_y_d = POS_W'(cand_y);
`ifdef PLAYER_ANIM_EN
                anim_d = anim_q + ACNT_W'(1);
                if (anim_d == ACNT_W'(ANIM_DIV)) begin
                    anim_d  = '0;
                    frame_d = ~frame_q;
                end
                sprite_d = base_sprite(dir_q) | {2'b00, frame_d};
`else
                sprite_d = base_sprite(dir_q);
`endif
                state_d = IDLE;
            end

            DEAD: begin
                if (frame_tick) begin
                    if (death_cnt_q <= DCNT_W'(1)) begin
                        death_cnt_d = '0;
                        pos_x_d     = POS_W'(START_X);
                        pos_y_d     = POS_W'(START_Y);
                        sprite_d    = SPR_DOWN;
                        dir_d       = DOWN;
                        alive_d     = 1'b1;
                        state_d     = IDLE;
`ifdef PLAYER_ANIM_EN
                        anim_d      = '0;
                        frame_d     = 1'b0;
`endif
                    end else begin
                        death_cnt_d = death_cnt_q - DCNT_W'(1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // A hit aborts anything in flight; any later ack lands in DEAD and is ignored.
        if (hit && state_q != DEAD) begin
            state_d     = DEAD;
            map_req_d   = 1'b0;
            alive_d     = 1'b0;
            sprite_d    = SPR_DEAD;
            death_cnt_d = DCNT_W'(DEATH_FRAMES);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            dir_q       <= DOWN;
            pos_x_q     <= POS_W'(START_X);
            pos_y_q     <= POS_W'(START_Y);
            sprite_q    <= SPR_DOWN;
            map_req_q   <= 1'b0;
            tile_q      <= '0;
            alive_q     <= 1'b1;
            death_cnt_q <= '0;
`ifdef PLAYER_ANIM_EN
            anim_q      <= '0;
            frame_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            sprite_q    <= sprite_d;
            map_req_q   <= map_req_d;
            tile_q      <= tile_d;
            alive_q     <= alive_d;
            death_cnt_q <= death_cnt_d;
`ifdef PLAYER_ANIM_EN
            anim_q      <= anim_d;
            frame_q     <= frame_d;
`endif
        end
    end

    assign map_req    = map_req_q;
    assign map_tx     = tile_q.tx;
    assign map_ty     = tile_q.ty;
    assign centerX1   = pos_x_q;
    assign centerY1   = pos_y_q;
    assign sprite_num = sprite_q;
    assign alive      = alive_q;

endmodule
